// File: rtl/alu_result_stage.sv
// alu_result_stage: registered stage after the ALU. Keeps the NZCV flags,
// evaluates each beat's condition code against them and forwards passing
// results to write-back through a 2-entry skid buffer.
//
// Handshake: a beat moves on a port when valid & ready are both high at a
// rising clk edge; valid and its payload stay stable until that happens.
// in_ready is a register ("buffer not full after this edge"), so out_ready
// never reaches in_ready combinationally.
module alu_result_stage #(
    parameter int WIDTH  = 8,
    parameter int ADDR_W = 4
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [WIDTH-1:0]  in_result,
    input  logic              in_co,
    input  logic              in_ovf,
    input  logic              in_n,
    input  logic              in_z,
    input  logic              in_set,
    input  logic [3:0]        in_cond,
    input  logic [ADDR_W-1:0] in_rd,
    input  logic              flag_load,
    input  logic [3:0]        flag_din,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [WIDTH-1:0]  out_data,
    output logic [ADDR_W-1:0] out_rd,
    output logic [3:0]        flags,
    output logic              carry,
    output logic [15:0]       squash_cnt
);

    // Condition check against {N,Z,C,V}
    function automatic logic cond_pass(input logic [3:0] cc, input logic [3:0] f);
        logic n, z, c, v;
        n = f[3];
        z = f[2];
        c = f[1];
        v = f[0];
        case (cc)
            4'b0000: cond_pass = z;
            4'b0001: cond_pass = ~z;
            4'b0010: cond_pass = c;
            4'b0011: cond_pass = ~c;
            4'b0100: cond_pass = n;
            4'b0101: cond_pass = ~n;
            4'b0110: cond_pass = v;
            4'b0111: cond_pass = ~v;
            4'b1000: cond_pass = c & ~z;
            4'b1001: cond_pass = ~c | z;
            4'b1010: cond_pass = (n == v);
            4'b1011: cond_pass = (n != v);
            4'b1100: cond_pass = ~z & (n == v);
            4'b1101: cond_pass = z | (n != v);
            default: cond_pass = 1'b1;
        endcase
    endfunction

    logic [WIDTH-1:0]  data_q [2];
    logic [ADDR_W-1:0] rd_q   [2];
    logic              wr_ptr_q, wr_ptr_d;
    logic              rd_ptr_q, rd_ptr_d;
    logic [1:0]        count_q, count_d;
    logic              in_ready_q, in_ready_d;
    logic [3:0]        flags_q, flags_d;
    logic [15:0]       squash_q, squash_d;

    logic accept, pass, push, pop;

    // Handshake decode, flag update, squash counting and buffer bookkeeping
    always_comb begin
        accept     = in_valid & in_ready_q;
        pass       = cond_pass(in_cond, flags_q);
        push       = accept & pass;
        pop        = (count_q != 2'd0) & out_ready;
        flags_d    = flags_q;
        squash_d   = squash_q;
        wr_ptr_d   = wr_ptr_q;
        rd_ptr_d   = rd_ptr_q;
        count_d    = count_q;
        if (push && in_set) begin
            flags_d = {in_n, in_z, in_co, in_ovf};
        end
        // A direct flag write overrides a flag-setting beat on the same edge
        if (flag_load) begin
            flags_d = flag_din;
        end
        if (accept && !pass && squash_q != 16'hFFFF) begin
            squash_d = squash_q + 16'd1;
        end
        if (push) begin
            wr_ptr_d = ~wr_ptr_q;
        end
        if (pop) begin
            rd_ptr_d = ~rd_ptr_q;
        end
        if (push && !pop) begin
            count_d = count_q + 2'd1;
        end else if (!push && pop) begin
            count_d = count_q - 2'd1;
        end
        in_ready_d = (count_d != 2'd2);
    end

    // State registers with synchronous reset; reset also clears the payload
    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr_q   <= 1'b0;
            rd_ptr_q   <= 1'b0;
            count_q    <= 2'd0;
            in_ready_q <= 1'b1;
            flags_q    <= 4'b0000;
            squash_q   <= 16'd0;
            data_q[0]  <= '0;
            data_q[1]  <= '0;
            rd_q[0]    <= '0;
            rd_q[1]    <= '0;
        end else begin
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            count_q    <= count_d;
            in_ready_q <= in_ready_d;
            flags_q    <= flags_d;
            squash_q   <= squash_d;
            if (push) begin
                data_q[wr_ptr_q] <= in_result;
                rd_q[wr_ptr_q]   <= in_rd;
            end
        end
    end

    // Outputs come straight from registers; the head entry holds while stalled
    always_comb begin
        in_ready   = in_ready_q;
        out_valid  = (count_q != 2'd0);
        out_data   = data_q[rd_ptr_q];
        out_rd     = rd_q[rd_ptr_q];
        flags      = flags_q;
        carry      = flags_q[1];
        squash_cnt = squash_q;
    end

endmodule
